limits_frame_buffer_ctrl: RTL and testbench
===========================================

Name: limits_frame_buffer_ctrl

Overview:
Parametrised successor of the limits buffer controller. It sits between the level generator and the hard limiter. It stores one frame of limit samples into a dual-port on-chip RAM through port A, then replays the stored frame through port B once per reconstruction iteration. Changes from the previous controller:
- parametrised width and depth
- full waitrequest and read-latency handling
- output backpressure
- fill/overflow status
- frame-done signalling to the iteration controller

Parameters:
DATA_W, 32, sample width and RAM data width.
ADDR_W, 8, RAM word-address width.
DEPTH, 255, maximum samples per frame; legal range 2..2**ADDR_W.
RD_LATENCY, 2, fixed cycles from an accepted port-B read to valid readdata; legal range 1..4.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous frame clear: empties buffer, aborts replay
lvl_gen_data  in  DATA_W  sample from level generator
lvl_gen_valid  in  1  sample valid
lvl_gen_ready  out  1  controller can accept sample
iter_input_enable  in  1  capture window open
iter_output_enable  in  1  level: replay requested
iter_frame_done  out  1  one-cycle pulse, last sample of a replay delivered
limiter_data  out  DATA_W  sample to hard limiter
limiter_valid  out  1  sample valid
limiter_ready  in  1  hard limiter accepts sample
fill_level  out  ADDR_W+1  samples stored in current frame
overflow  out  1  sticky: sample offered while full; cleared by clear/reset
ram_limits_address_a  out  ADDR_W  port A word address
ram_limits_chipselect_a  out  1  port A chipselect
ram_limits_write_a  out  1  port A write
ram_limits_writedata_a  out  DATA_W  port A write data
ram_limits_byteenable_a  out  DATA_W/8  all ones
ram_limits_waitrequest_a  in  1  port A stall
ram_limits_address_b  out  ADDR_W  port B word address
ram_limits_chipselect_b  out  1  port B chipselect
ram_limits_read_b  out  1  port B read
ram_limits_readdata_b  in  DATA_W  port B read data
ram_limits_waitrequest_b  in  1  port B stall

Behaviour:
Reset values:
- All outputs are 0 except both byteenables, which are all ones.
- Both FSMs go to IDLE.
- wr_ptr = rd_ptr = 0.

Write path (FSM WIDLE / WRITE):
- lvl_gen_ready = iter_input_enable & ~full & ~(write pending).
- Handshake: lvl_gen_valid & lvl_gen_ready. On handshake, register address = wr_ptr, data, and write = 1.
- Avalon rule: address, data and write stay stable while waitrequest_a = 1. The write completes on the first cycle with waitrequest_a = 0; then wr_ptr++ and fill_level++.
- full = (fill_level == DEPTH). lvl_gen_valid & iter_input_enable while full sets overflow; the sample is dropped and not written.
- iter_input_enable falling mid-stall does not abort the pending write.

Read path (FSM RIDLE / REPLAY / DRAIN):
- RIDLE -> REPLAY when iter_output_enable = 1 and fill_level > 0. On entry, rd_ptr = 0.
- Read issue condition: read_b = 1 when in REPLAY, rd_ptr < fill_level, and credits > 0.
  - credits = (RD_LATENCY + 1) − (outstanding reads + skid FIFO occupancy).
  - The read is accepted on a cycle with waitrequest_b = 0; then rd_ptr++.
  - address_b = rd_ptr, held stable while stalled.
- Each accepted read shifts a tag into an RD_LATENCY-deep valid pipe. readdata_b is captured into the skid FIFO (depth RD_LATENCY+1) when the tag emerges.
- Output: limiter_valid = skid FIFO not empty; limiter_data = FIFO head. Pop when limiter_valid & limiter_ready.
- REPLAY -> DRAIN after the last read is accepted (rd_ptr == fill_level).
- DRAIN -> RIDLE when the pipe and FIFO are empty. iter_frame_done pulses in the same cycle as the final pop.
- After returning to RIDLE, a new replay starts only after iter_output_enable has been seen low, then high again (rising edge re-arms). Frames are never replayed back-to-back by level alone.
- iter_output_enable falling during REPLAY stops issuing new reads. The FSM goes to DRAIN, delivers in-flight data, and does not pulse iter_frame_done.

Simultaneous and boundary cases:
- A write and a replay in the same frame are allowed. The replay reads only up to the fill_level latched at replay start.
- clear: resets both FSMs, pointers, fill_level, overflow, pipe and FIFO next cycle. A pending port-A write that is stalled is held until accepted, then discarded from the count.
- Async reset mid-transfer returns everything to the reset values immediately.
- Throughput: 1 sample/cycle on each side with no stalls.
- Read latency from accepted read to limiter_valid is RD_LATENCY+1 cycles.

Decomposition:
- Package limits_buf_pkg: typedefs wr_state_t {WIDLE, WRITE}, rd_state_t {RIDLE, REPLAY, DRAIN}; helper function clog2-based FIFO index width.
- One sub-module: limits_skid_fifo (DATA_W, DEPTH = RD_LATENCY+1, synchronous push/pop, count output).

Test Plan:
1. Fill 10 samples 0x100..0x109 with no waitrequest; then iter_output_enable edge with limiter_ready = 1 -> limiter sees 0x100..0x109 in order, one per cycle, and iter_frame_done pulses with 0x109; fill_level = 10.
2. waitrequest_a high for 3 cycles on the 4th write -> address/data held stable, lvl_gen_ready = 0 during the stall, no sample lost, fill_level ends at the offered count.
3. DEPTH = 4, offer 6 samples -> 4 stored, lvl_gen_ready = 0 after the 4th, overflow = 1 and sticky; clear -> overflow = 0, fill_level = 0.
4. Replay of 8 samples with limiter_ready toggling 1/0 every cycle and waitrequest_b random -> exact sequence delivered, no duplicates or drops, FIFO never overflows (assertion).
5. iter_output_enable dropped after 3 reads -> at most RD_LATENCY+1 further samples delivered, no iter_frame_done, FSM returns to RIDLE; next edge replays from address 0.
6. Reset asserted asynchronously mid-replay -> all outputs 0 (byteenables all ones) within the same cycle, FSMs in IDLE after release.

Source files
------------

// File: rtl/limits_buf_pkg.sv
// Shared types and sizing helpers for the limits frame buffer controller.
package limits_buf_pkg;

    typedef logic [0:0] wr_state_t;
    localparam wr_state_t WIDLE = 1'b0;
    localparam wr_state_t WRITE = 1'b1;

    typedef logic [1:0] rd_state_t;
    localparam rd_state_t RIDLE  = 2'd0;
    localparam rd_state_t REPLAY = 2'd1;
    localparam rd_state_t DRAIN  = 2'd2;

    function automatic int fifo_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/limits_skid_fifo.sv
// Small circular skid FIFO catching port-B read data ahead of the hard limiter.
module limits_skid_fifo
    import limits_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             head,
    output logic                          empty,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count
);

    localparam int IW = fifo_idx_w(DEPTH);
    localparam int CW = fifo_cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IW-1:0]     wr_idx_q, wr_idx_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [IW-1:0] idx_next(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
    endfunction

    always_comb begin
        do_pop   = pop & (count_q != '0);
        // a simultaneous pop makes room, so a full FIFO may still take a push
        do_push  = push & ((count_q != CW'(DEPTH)) | do_pop);
        wr_idx_d = do_push ? idx_next(wr_idx_q) : wr_idx_q;
        rd_idx_d = do_pop  ? idx_next(rd_idx_q) : rd_idx_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (clear) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_idx_q] <= push_data;
    end

    assign head  = mem_q[rd_idx_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/limits_frame_buffer_ctrl.sv
// Captures one frame of limit samples into RAM port A and replays it through
// port B to the hard limiter once per reconstruction iteration.
//
//   state  | meaning
//   WIDLE  | no port-A write outstanding
//   WRITE  | port-A write presented, held until waitrequest_a drops
//   RIDLE  | waiting for a re-armed iter_output_enable and a non-empty frame
//   REPLAY | issuing port-B reads up to the frame length latched at start
//   DRAIN  | no more reads; delivering in-flight data to the limiter
module limits_frame_buffer_ctrl
    import limits_buf_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 255,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     lvl_gen_data,
    input  logic                  lvl_gen_valid,
    output logic                  lvl_gen_ready,
    input  logic                  iter_input_enable,
    input  logic                  iter_output_enable,
    output logic                  iter_frame_done,
    output logic [DATA_W-1:0]     limiter_data,
    output logic                  limiter_valid,
    input  logic                  limiter_ready,
    output logic [ADDR_W:0]       fill_level,
    output logic                  overflow,
    output logic [ADDR_W-1:0]     ram_limits_address_a,
    output logic                  ram_limits_chipselect_a,
    output logic                  ram_limits_write_a,
    output logic [DATA_W-1:0]     ram_limits_writedata_a,
    output logic [DATA_W/8-1:0]   ram_limits_byteenable_a,
    input  logic                  ram_limits_waitrequest_a,
    output logic [ADDR_W-1:0]     ram_limits_address_b,
    output logic                  ram_limits_chipselect_b,
    output logic                  ram_limits_read_b,
    input  logic [DATA_W-1:0]     ram_limits_readdata_b,
    input  logic                  ram_limits_waitrequest_b
);

    localparam int FDEPTH = RD_LATENCY + 1;
    localparam int CW     = fifo_cnt_w(FDEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // write path
    wr_state_t         wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              discard_q, discard_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic              overflow_q, overflow_d;
    logic              wr_stall, wr_done, wr_full, wr_accept;
    logic [ADDR_W:0]   fill_after;

    always_comb begin
        wr_stall = (wr_state_q == WRITE) & ram_limits_waitrequest_a;
        wr_done  = (wr_state_q == WRITE) & ~ram_limits_waitrequest_a;

        fill_after = fill_q;
        if (clear)                        fill_after = '0;
        else if (wr_done & ~discard_q)    fill_after = fill_q + (ADDR_W + 1)'(1);

        // fullness includes a write completing this cycle so the stream runs 1/cycle
        wr_full       = (fill_after == DEPTH_C);
        lvl_gen_ready = iter_input_enable & ~clear & ~wr_stall & ~wr_full;
        wr_accept     = lvl_gen_valid & lvl_gen_ready;

        wr_state_d = wr_state_q;
        addr_a_d   = addr_a_q;
        wdata_d    = wdata_q;
        if (wr_accept) begin
            wr_state_d = WRITE;
            addr_a_d   = fill_after[ADDR_W-1:0];
            wdata_d    = lvl_gen_data;
        end else if (wr_done) begin
            wr_state_d = WIDLE;
        end

        discard_d = discard_q;
        if (clear & wr_stall) discard_d = 1'b1;
        else if (wr_done)     discard_d = 1'b0;

        fill_d     = fill_after;
        overflow_d = clear ? 1'b0
                   : overflow_q | (lvl_gen_valid & iter_input_enable & wr_full & ~wr_stall);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_state_q <= WIDLE;
            addr_a_q   <= '0;
            wdata_q    <= '0;
            discard_q  <= 1'b0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            addr_a_q   <= addr_a_d;
            wdata_q    <= wdata_d;
            discard_q  <= discard_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    // read path
    rd_state_t             rd_state_q, rd_state_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d, rd_ptr_next;
    logic [ADDR_W:0]       rd_len_q, rd_len_d;
    logic                  armed_q, armed_d;
    logic                  aborted_q, aborted_d;
    logic                  rd_hold_q, rd_hold_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [2:0]            outst;
    logic [3:0]            in_flight;
    logic                  rd_req, rd_accept, fifo_push, fifo_pop, fifo_empty;
    logic [CW-1:0]         fifo_cnt;
    logic [DATA_W-1:0]     fifo_head;

    always_comb begin
        outst = '0;
        for (int i = 0; i < RD_LATENCY; i++) outst = outst + 3'(pipe_q[i]);

        fifo_pop  = ~fifo_empty & limiter_ready;
        // a pop this cycle returns its credit immediately to keep 1 read/cycle
        in_flight = 4'(outst) + 4'(fifo_cnt) - 4'(fifo_pop);
        rd_req    = (rd_state_q == REPLAY) & (rd_ptr_q < rd_len_q)
                  & (in_flight < 4'(FDEPTH)) & (iter_output_enable | rd_hold_q);
        rd_accept = rd_req & ~ram_limits_waitrequest_b;
        rd_hold_d = ~clear & rd_req & ram_limits_waitrequest_b;
        rd_ptr_next = rd_ptr_q + (ADDR_W + 1)'(rd_accept);

        pipe_d[0] = rd_accept;
        for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
        fifo_push = pipe_q[RD_LATENCY-1];

        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_len_d   = rd_len_q;
        aborted_d  = aborted_q;
        armed_d    = armed_q | ~iter_output_enable;

        case (rd_state_q)
            RIDLE: begin
                if (armed_q & iter_output_enable & (fill_q != '0)) begin
                    rd_state_d = REPLAY;
                    rd_ptr_d   = '0;
                    rd_len_d   = fill_q;
                    aborted_d  = 1'b0;
                    armed_d    = 1'b0;
                end
            end
            REPLAY: begin
                rd_ptr_d = rd_ptr_next;
                if (~iter_output_enable & ~(rd_req & ram_limits_waitrequest_b)) begin
                    rd_state_d = DRAIN;
                    aborted_d  = (rd_ptr_next != rd_len_q);
                end else if (rd_ptr_next == rd_len_q) begin
                    rd_state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((pipe_q == '0) & ((fifo_cnt == '0) | ((fifo_cnt == CW'(1)) & fifo_pop)))
                    rd_state_d = RIDLE;
            end
            default: rd_state_d = RIDLE;
        endcase

        if (clear) begin
            rd_state_d = RIDLE;
            rd_ptr_d   = '0;
            rd_len_d   = '0;
            aborted_d  = 1'b0;
            pipe_d     = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_state_q <= RIDLE;
            rd_ptr_q   <= '0;
            rd_len_q   <= '0;
            armed_q    <= 1'b1;
            aborted_q  <= 1'b0;
            rd_hold_q  <= 1'b0;
            pipe_q     <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_len_q   <= rd_len_d;
            armed_q    <= armed_d;
            aborted_q  <= aborted_d;
            rd_hold_q  <= rd_hold_d;
            pipe_q     <= pipe_d;
        end
    end

    limits_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FDEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .push      (fifo_push),
        .push_data (ram_limits_readdata_b),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign limiter_valid   = ~fifo_empty;
    assign limiter_data    = fifo_empty ? '0 : fifo_head;
    assign iter_frame_done = (rd_state_q == DRAIN) & ~aborted_q & (pipe_q == '0)
                           & (fifo_cnt == CW'(1)) & fifo_pop;

    assign fill_level              = fill_q;
    assign overflow                = overflow_q;
    assign ram_limits_address_a    = addr_a_q;
    assign ram_limits_chipselect_a = (wr_state_q == WRITE);
    assign ram_limits_write_a      = (wr_state_q == WRITE);
    assign ram_limits_writedata_a  = wdata_q;
    assign ram_limits_byteenable_a = '1;
    assign ram_limits_address_b    = rd_ptr_q[ADDR_W-1:0];
    assign ram_limits_chipselect_b = rd_req;
    assign ram_limits_read_b       = rd_req;

endmodule

// File: tb/tb_limits_frame_buffer_ctrl.sv
// Directed bench for limits_frame_buffer_ctrl with a behavioural dual-port RAM.
module tb_limits_frame_buffer_ctrl;
    import limits_buf_pkg::*;

    localparam int L = 2;

    logic        clock, reset, clear;
    logic [31:0] lvl_data;
    logic        lvl_valid, ien, oen, lim_ready, wait_a, wait_b;
    logic        lvl_ready, frame_done, lim_valid, overflow;
    logic [31:0] lim_data, wdata_a, rdata_b;
    logic [8:0]  fill;
    logic [7:0]  addr_a, addr_b;
    logic        cs_a, wr_a, cs_b, rd_b;
    logic [3:0]  be_a;

    logic        d4_ready, d4_done, d4_valid, d4_ovf, d4_cs_a, d4_wr_a, d4_cs_b, d4_rd_b;
    logic [31:0] d4_data, d4_wdata;
    logic [8:0]  d4_fill;
    logic [7:0]  d4_addr_a, d4_addr_b;
    logic [3:0]  d4_be;

    limits_frame_buffer_ctrl u_dut (
        .clock(clock), .reset(reset), .clear(clear),
        .lvl_gen_data(lvl_data), .lvl_gen_valid(lvl_valid), .lvl_gen_ready(lvl_ready),
        .iter_input_enable(ien), .iter_output_enable(oen), .iter_frame_done(frame_done),
        .limiter_data(lim_data), .limiter_valid(lim_valid), .limiter_ready(lim_ready),
        .fill_level(fill), .overflow(overflow),
        .ram_limits_address_a(addr_a), .ram_limits_chipselect_a(cs_a),
        .ram_limits_write_a(wr_a), .ram_limits_writedata_a(wdata_a),
        .ram_limits_byteenable_a(be_a), .ram_limits_waitrequest_a(wait_a),
        .ram_limits_address_b(addr_b), .ram_limits_chipselect_b(cs_b),
        .ram_limits_read_b(rd_b), .ram_limits_readdata_b(rdata_b),
        .ram_limits_waitrequest_b(wait_b)
    );

    limits_frame_buffer_ctrl #(.DEPTH(4)) u_dut4 (
        .clock(clock), .reset(reset), .clear(clear),
        .lvl_gen_data(lvl_data), .lvl_gen_valid(lvl_valid), .lvl_gen_ready(d4_ready),
        .iter_input_enable(ien), .iter_output_enable(oen), .iter_frame_done(d4_done),
        .limiter_data(d4_data), .limiter_valid(d4_valid), .limiter_ready(lim_ready),
        .fill_level(d4_fill), .overflow(d4_ovf),
        .ram_limits_address_a(d4_addr_a), .ram_limits_chipselect_a(d4_cs_a),
        .ram_limits_write_a(d4_wr_a), .ram_limits_writedata_a(d4_wdata),
        .ram_limits_byteenable_a(d4_be), .ram_limits_waitrequest_a(wait_a),
        .ram_limits_address_b(d4_addr_b), .ram_limits_chipselect_b(d4_cs_b),
        .ram_limits_read_b(d4_rd_b), .ram_limits_readdata_b(32'h0),
        .ram_limits_waitrequest_b(wait_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // RAM model: port-B data appears L cycles after an accepted read
    logic [31:0] mem [256];
    logic [7:0]  rpipe0, rpipe1;
    always @(posedge clock) begin
        if (cs_a && wr_a && !wait_a) mem[addr_a] <= wdata_a;
        rpipe0 <= addr_b;
        rpipe1 <= rpipe0;
    end
    assign rdata_b = mem[rpipe1];

    // port-A stall generator for the waitrequest scenario
    logic stall_arm;
    int   stall_n;
    always @(posedge clock) begin
        #1;
        if (stall_arm && wr_a && addr_a == 8'd3 && stall_n < 3) begin
            wait_a = 1'b1;
            stall_n++;
        end else begin
            wait_a = 1'b0;
        end
    end

    int          cyc, done_cnt, rd_acc, a_viol, b_viol, rdy_viol, fifo_viol;
    logic [31:0] done_data;
    logic        done_pop;
    logic [31:0] got_q[$], wr_d_q[$];
    logic [7:0]  wr_a_q[$], rd_addr_q[$];
    int          pop_cyc[$], rd_cyc[$];
    logic        p_stall_a, p_stall_b;
    logic [7:0]  p_addr_a, p_addr_b;
    logic [31:0] p_wdata;

    always @(negedge clock) begin
        cyc++;
        if (lim_valid && lim_ready) begin
            got_q.push_back(lim_data);
            pop_cyc.push_back(cyc);
        end
        if (frame_done) begin
            done_cnt++;
            done_data = lim_data;
            done_pop  = lim_valid & lim_ready;
        end
        if (rd_b && !wait_b) begin
            rd_acc++;
            rd_cyc.push_back(cyc);
            rd_addr_q.push_back(addr_b);
        end
        if (wr_a && !wait_a) begin
            wr_a_q.push_back(addr_a);
            wr_d_q.push_back(wdata_a);
        end
        if (!reset) begin
            if (p_stall_a && (!wr_a || addr_a != p_addr_a || wdata_a != p_wdata)) a_viol++;
            if (p_stall_b && (!rd_b || addr_b != p_addr_b)) b_viol++;
        end
        if (wr_a && wait_a && lvl_ready) rdy_viol++;
        if (u_dut.u_fifo.count > 2'd3) fifo_viol++;
        p_stall_a = wr_a & wait_a & !reset;
        p_stall_b = rd_b & wait_b & !reset;
        p_addr_a  = addr_a;
        p_addr_b  = addr_b;
        p_wdata   = wdata_a;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        logic ok;
        int   g;
        ok = 1'b0;
        g  = 0;
        lvl_valid = 1'b1;
        lvl_data  = d;
        while (!ok && g < 50) begin
            @(negedge clock);
            ok = lvl_ready;
            tick();
            g++;
        end
        if (!ok) chk("push_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input int done0, input int budget);
        int g;
        g = 0;
        while (done_cnt == done0 && g < budget) begin
            tick();
            g++;
        end
        chk("frame_done_count", 64'(done_cnt - done0), 64'd1);
    endtask

    task automatic chk_seq(input string tag, input logic [31:0] base, input int n);
        int bad;
        bad = 0;
        chk({tag, "_len"}, 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n && i < got_q.size(); i++)
            if (got_q[i] !== base + 32'(i)) bad++;
        chk({tag, "_order"}, 64'(bad), 64'd0);
    endtask

    int          t0, t1, d0, a0, bad;
    logic [5:0]  r4;

    initial begin
        reset = 1'b1; clear = 1'b0; lvl_data = '0; lvl_valid = 1'b0;
        ien = 1'b0; oen = 1'b0; lim_ready = 1'b0; wait_b = 1'b0; wait_a = 1'b0;
        stall_arm = 1'b0; stall_n = 0;
        cyc = 0; done_cnt = 0; rd_acc = 0; a_viol = 0; b_viol = 0; rdy_viol = 0; fifo_viol = 0;
        p_stall_a = 1'b0; p_stall_b = 1'b0;
        repeat (2) tick();

        chk("rst_fill", 64'(fill), 64'd0);
        chk("rst_outputs", 64'({lvl_ready, frame_done, lim_valid, overflow, cs_a, wr_a, cs_b, rd_b}), 64'd0);
        chk("rst_data", 64'({lim_data, wdata_a}), 64'd0);
        chk("rst_addr", 64'({addr_a, addr_b}), 64'd0);
        chk("rst_byteen", 64'({be_a, d4_be}), 64'hff);
        reset = 1'b0;
        tick();

        // 1: basic fill and full-rate replay
        ien = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
        t1 = cyc;
        lvl_valid = 1'b0;
        tick(); tick();
        chk("t1_fill", 64'(fill), 64'd10);
        chk("t1_write_rate", 64'(t1 - t0), 64'd10);
        bad = 0;
        for (int i = 0; i < 10; i++) if (wr_a_q[i] !== 8'(i) || wr_d_q[i] !== 32'h100 + 32'(i)) bad++;
        chk("t1_write_log", 64'(bad), 64'd0);
        got_q.delete(); pop_cyc.delete(); rd_cyc.delete();
        d0 = done_cnt;
        lim_ready = 1'b1;
        oen = 1'b1;
        wait_done(d0, 100);
        chk_seq("t1_replay", 32'h100, 10);
        chk("t1_done_data", 64'(done_data), 64'h109);
        chk("t1_done_with_pop", 64'(done_pop), 64'd1);
        chk("t1_out_rate", 64'(pop_cyc[9] - pop_cyc[0]), 64'd9);
        chk("t1_latency", 64'(pop_cyc[0] - rd_cyc[0]), 64'(L + 1));
        repeat (20) tick();
        chk("t1_no_level_rerun", 64'(got_q.size()), 64'd10);
        oen = 1'b0;

        // 2: port-A waitrequest on the 4th write
        clear = 1'b1; tick(); clear = 1'b0; tick();
        chk("t2_clear_fill", 64'(fill), 64'd0);
        wr_a_q.delete(); wr_d_q.delete();
        stall_arm = 1'b1;
        for (int i = 0; i < 6; i++) push(32'h200 + 32'(i));
        lvl_valid = 1'b0;
        repeat (3) tick();
        stall_arm = 1'b0;
        chk("t2_stall_cycles", 64'(stall_n), 64'd3);
        chk("t2_fill", 64'(fill), 64'd6);
        bad = 0;
        for (int i = 0; i < 6; i++) if (wr_a_q[i] !== 8'(i) || wr_d_q[i] !== 32'h200 + 32'(i)) bad++;
        chk("t2_write_log", 64'({bad, 8'(wr_a_q.size())}), 64'({32'd0, 8'd6}));
        chk("t2_hold_stable", 64'(a_viol), 64'd0);
        chk("t2_ready_in_stall", 64'(rdy_viol), 64'd0);

        // 3: overflow on the DEPTH=4 instance
        clear = 1'b1; tick(); clear = 1'b0; tick();
        for (int i = 0; i < 6; i++) begin
            lvl_valid = 1'b1;
            lvl_data  = 32'h300 + 32'(i);
            @(negedge clock);
            r4[i] = d4_ready;
            tick();
        end
        lvl_valid = 1'b0;
        tick();
        chk("t3_ready_pattern", 64'(r4), 64'h0f);
        chk("t3_fill4", 64'(d4_fill), 64'd4);
        chk("t3_overflow", 64'(d4_ovf), 64'd1);
        repeat (5) tick();
        chk("t3_overflow_sticky", 64'(d4_ovf), 64'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t3_clear_ovf_fill", 64'({d4_ovf, d4_fill}), 64'd0);
        chk("t3_main_no_ovf", 64'(overflow), 64'd0);

        // 4: replay under limiter backpressure and random port-B stalls
        tick();
        for (int i = 0; i < 8; i++) push(32'h400 + 32'(i));
        lvl_valid = 1'b0;
        tick(); tick();
        chk("t4_fill", 64'(fill), 64'd8);
        got_q.delete();
        d0 = done_cnt;
        lim_ready = 1'b0;
        oen = 1'b1;
        begin
            int g;
            g = 0;
            while (done_cnt == d0 && g < 300) begin
                tick();
                lim_ready = ~lim_ready;
                wait_b    = 1'($urandom_range(0, 1));
                g++;
            end
        end
        lim_ready = 1'b1;
        wait_b    = 1'b0;
        chk("t4_frame_done", 64'(done_cnt - d0), 64'd1);
        chk_seq("t4_replay", 32'h400, 8);
        chk("t4_done_data", 64'(done_data), 64'h407);
        chk("t4_b_hold_stable", 64'(b_viol), 64'd0);
        chk("t4_fifo_bound", 64'(fifo_viol), 64'd0);

        // 5: replay aborted after three reads, then restarted
        oen = 1'b0; tick(); tick();
        got_q.delete(); rd_addr_q.delete();
        d0 = done_cnt;
        a0 = rd_acc;
        oen = 1'b1;
        begin
            int g;
            g = 0;
            while (rd_acc - a0 < 3 && g < 50) begin
                @(negedge clock);
                #1;
                g++;
            end
        end
        tick();
        oen = 1'b0;
        repeat (20) tick();
        chk("t5_reads_issued", 64'(rd_acc - a0), 64'd3);
        chk_seq("t5_partial", 32'h400, 3);
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t5_state_ridle", 64'(u_dut.rd_state_q), 64'(RIDLE));
        got_q.delete(); rd_addr_q.delete();
        oen = 1'b1;
        wait_done(d0, 100);
        chk("t5_restart_addr", 64'(rd_addr_q[0]), 64'd0);
        chk_seq("t5_full", 32'h400, 8);

        // 6: asynchronous reset mid-replay
        oen = 1'b0; tick();
        oen = 1'b1;
        repeat (5) tick();
        @(negedge clock);
        chk("t6_busy_before", 64'({lim_valid, rd_b}), 64'h3);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_ctrl", 64'({lim_valid, rd_b, cs_b, frame_done, wr_a, overflow}), 64'd0);
        chk("t6_async_data", 64'({lim_data, addr_b, fill}), 64'd0);
        chk("t6_async_byteen", 64'(be_a), 64'hf);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("t6_fsm_idle", 64'({u_dut.rd_state_q, u_dut.wr_state_q}), 64'({RIDLE, WIDLE}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
